// File: rtl/l5_pkg.sv
// Shared definitions for the L4 reader / L5 feature streaming path.
package l5_pkg;

    localparam int FEAT_WIDTH    = 16;
    localparam int L4_BANK_DEPTH = 200;
    localparam int FEAT_VEC_LEN  = 2 * L4_BANK_DEPTH;

    typedef logic [FEAT_WIDTH-1:0] feat_word_t;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_FETCH = 4'b0010,
        S_DRAIN = 4'b0100,
        S_DONE  = 4'b1000
    } l5_state_t;

endpackage

// File: rtl/feat_skid_fifo.sv
// Small synchronous FIFO absorbing BRAM read latency; head word is presented
// directly from storage and forced to zero while empty.
module feat_skid_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               push,
    input  logic [DATA_WIDTH-1:0]              push_data,
    input  logic                               pop,
    output logic [DATA_WIDTH-1:0]              head_data,
    output logic [$clog2(FIFO_DEPTH + 1)-1:0]  count,
    output logic                               empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  wr_en;
    logic                  rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign wr_en     = push && !full;
    assign rd_en     = pop && !empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; only the pointers and count are, and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full))
        else $error("feat_skid_fifo: push arrived while FIFO was full");

endmodule

// File: rtl/l4_feature_streamer.sv
// Reads both L4 pooled-output banks and replays the 400-word feature vector once per L5 neuron.
module l4_feature_streamer
    import l5_pkg::*;
#(
    parameter int DATA_WIDTH    = FEAT_WIDTH,
    parameter int MAP_SIZE      = 25,
    parameter int MAPS_PER_BANK = 8,
    parameter int NUM_PASSES    = 120,
    parameter int RD_LAT        = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  L5_en,
    output logic [7:0]            L4_read_addr,
    input  logic [DATA_WIDTH-1:0] L4_read_data1,
    input  logic [DATA_WIDTH-1:0] L4_read_data2,
    output logic [DATA_WIDTH-1:0] feat_data,
    output logic                  feat_valid,
    input  logic                  feat_ready,
    output logic [8:0]            feat_index,
    output logic                  feat_last,
    output logic [6:0]            pass_count,
    output logic                  pass_last,
    output logic                  L5_done
);

    localparam int BANK_DEPTH = MAP_SIZE * MAPS_PER_BANK;
    localparam int VEC_LEN    = 2 * BANK_DEPTH;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    l5_state_t             state;
    l5_state_t             state_next;
    logic                  rd_bank;
    logic [6:0]            fetch_pass;
    logic [RD_LAT-1:0]     lat_valid;
    logic [RD_LAT-1:0]     lat_bank;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W:0]        credit_used;
    logic                  fifo_empty;
    logic                  issue;
    logic                  last_issue;
    logic                  pop;
    logic                  abort;
    logic                  clear;
    logic                  drain_done;
    logic [DATA_WIDTH-1:0] push_data;

    // Words in the FIFO plus reads still in the BRAM pipe never exceed FIFO_DEPTH.
    assign inflight    = CNT_W'($countones(lat_valid));
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue       = (state == S_FETCH) && L5_en && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign last_issue  = issue && rd_bank && (L4_read_addr == 8'(BANK_DEPTH - 1))
                         && (fetch_pass == 7'(NUM_PASSES - 1));

    assign feat_valid  = !fifo_empty;
    assign pop         = feat_valid && feat_ready;
    assign abort       = !L5_en && ((state == S_FETCH) || (state == S_DRAIN));
    assign clear       = abort || (state == S_IDLE);
    assign drain_done  = (inflight == '0) && (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));
    assign push_data   = lat_bank[RD_LAT-1] ? L4_read_data2 : L4_read_data1;

    assign feat_last   = (feat_index == 9'(VEC_LEN - 1));
    assign pass_last   = (pass_count == 7'(NUM_PASSES - 1));
    assign L5_done     = (state == S_DONE);

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (L5_en) state_next = S_FETCH;
            S_FETCH: if (!L5_en) state_next = S_IDLE;
                     else if (last_issue) state_next = S_DRAIN;
            S_DRAIN: if (!L5_en) state_next = S_IDLE;
                     else if (drain_done) state_next = S_DONE;
            S_DONE:  if (!L5_en) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            L4_read_addr <= '0;
            rd_bank      <= 1'b0;
            fetch_pass   <= '0;
            lat_valid    <= '0;
            lat_bank     <= '0;
        end else begin
            lat_valid[0] <= issue;
            lat_bank[0]  <= rd_bank;
            for (int i = 1; i < RD_LAT; i++) begin
                lat_valid[i] <= lat_valid[i-1];
                lat_bank[i]  <= lat_bank[i-1];
            end
            if (issue) begin
                if (L4_read_addr == 8'(BANK_DEPTH - 1)) begin
                    L4_read_addr <= '0;
                    rd_bank      <= !rd_bank;
                    if (rd_bank) fetch_pass <= fetch_pass + 7'd1;
                end else begin
                    L4_read_addr <= L4_read_addr + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            feat_index <= '0;
            pass_count <= '0;
        end else if (pop) begin
            if (feat_last) begin
                feat_index <= '0;
                pass_count <= pass_last ? 7'd0 : pass_count + 7'd1;
            end else begin
                feat_index <= feat_index + 9'd1;
            end
        end
    end

    feat_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear),
        .push      (lat_valid[RD_LAT-1]),
        .push_data (push_data),
        .pop       (pop),
        .head_data (feat_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_l4_feature_streamer.sv
// Self-checking bench: streams two replays of a synthetic L4 image and compares against an arithmetic model.
module tb_l4_feature_streamer;
    import l5_pkg::*;

    localparam int NP              = 2;
    localparam int VEC             = FEAT_VEC_LEN;
    localparam int TOTAL           = NP * VEC;
    localparam int LAT             = 2;
    localparam int FIRST_VALID_CYC = 1 + LAT + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       L5_en;
    logic [7:0] L4_read_addr;
    feat_word_t L4_read_data1;
    feat_word_t L4_read_data2;
    feat_word_t feat_data;
    logic       feat_valid;
    logic       feat_ready;
    logic [8:0] feat_index;
    logic       feat_last;
    logic [6:0] pass_count;
    logic       pass_last;
    logic       L5_done;

    always #5 clk = ~clk;

    l4_feature_streamer #(.NUM_PASSES(NP), .RD_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .L5_en         (L5_en),
        .L4_read_addr  (L4_read_addr),
        .L4_read_data1 (L4_read_data1),
        .L4_read_data2 (L4_read_data2),
        .feat_data     (feat_data),
        .feat_valid    (feat_valid),
        .feat_ready    (feat_ready),
        .feat_index    (feat_index),
        .feat_last     (feat_last),
        .pass_count    (pass_count),
        .pass_last     (pass_last),
        .L5_done       (L5_done)
    );

    // Two-cycle BRAM: bank0 word a = a, bank1 word a = 1000 + a.
    logic [7:0] a_q;
    always @(posedge clk) begin
        a_q           <= L4_read_addr;
        L4_read_data1 <= 16'(a_q);
        L4_read_data2 <= 16'(1000 + a_q);
    end

    typedef struct {
        int pop;
        int data;
        int idx;
        int last;
        int pass;
        int plast;
    } probe_t;

    typedef struct {
        int data;
        int idx;
        int last;
        int pass;
        int plast;
    } seen_t;

    probe_t     probes [8];
    seen_t      seen [TOTAL];
    int         n_checks = 0;
    int         n_pass = 0;
    int         exp_pos, cyc, first_valid_cyc, last_pop_cyc, done_cyc, last_count;
    bit         hold_pending;
    feat_word_t hold_data;
    logic [7:0] stall_addr;
    bit         found;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic reset_model();
        exp_pos         = 0;
        cyc             = 0;
        first_valid_cyc = -1;
        last_pop_cyc    = -1;
        done_cyc        = -1;
        last_count      = 0;
        hold_pending    = 1'b0;
    endtask

    task automatic start();
        reset_model();
        L5_en = 1'b1;
    endtask

    task automatic check_pop();
        int k, p, w;
        check("pop_in_range", exp_pos < TOTAL, 1);
        if (exp_pos < TOTAL) begin
            k = exp_pos % VEC;
            p = exp_pos / VEC;
            w = (k < L4_BANK_DEPTH) ? k : 1000 + k - L4_BANK_DEPTH;
            check("data", feat_data, w);
            check("index", feat_index, k);
            check("last", feat_last, k == VEC - 1);
            check("pass", pass_count, p);
            check("pass_last", pass_last, p == NP - 1);
            seen[exp_pos] = '{feat_data, feat_index, feat_last, pass_count, pass_last};
        end
        if (feat_last) last_count++;
        exp_pos++;
        last_pop_cyc = cyc;
    endtask

    task automatic observe();
        if (hold_pending) begin
            check("hold_valid", feat_valid, 1);
            check("hold_data", feat_data, hold_data);
        end
        hold_pending = feat_valid && !feat_ready;
        hold_data    = feat_data;
        if (feat_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (L5_done && done_cyc < 0) done_cyc = cyc;
        if (feat_valid && feat_ready) check_pop();
    endtask

    task automatic step(input int mode);
        @(negedge clk);
        cyc++;
        case (mode)
            0:       feat_ready = 1'b1;
            1:       feat_ready = 1'($urandom_range(0, 1));
            default: feat_ready = 1'b0;
        endcase
        observe();
    endtask

    task automatic run_to_done(input int mode, input int budget, input bit sustained);
        for (int i = 0; i < budget && done_cyc < 0; i++) step(mode);
        check("done_reached", done_cyc >= 0, 1);
        check("pop_total", exp_pos, TOTAL);
        check("done_after_last_pop", done_cyc, last_pop_cyc + 1);
        check("first_valid_latency", first_valid_cyc, FIRST_VALID_CYC);
        if (sustained) check("sustained_rate", last_pop_cyc - first_valid_cyc, TOTAL - 1);
    endtask

    task automatic done_hold_check();
        for (int i = 0; i < 5; i++) begin
            step(0);
            check("done_held", L5_done, 1);
            check("done_valid_low", feat_valid, 0);
        end
        L5_en = 1'b0;
        step(0);
        check("done_to_idle", L5_done, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, L4_read_addr, 0);
        check({tag, "_valid"}, feat_valid, 0);
        check({tag, "_data"}, feat_data, 0);
        check({tag, "_index"}, feat_index, 0);
        check({tag, "_last"}, feat_last, 0);
        check({tag, "_pass"}, pass_count, 0);
        check({tag, "_pass_last"}, pass_last, 0);
        check({tag, "_done"}, L5_done, 0);
    endtask

    initial begin
        probes[0] = '{0,   0,    0,   0, 0, 0};
        probes[1] = '{199, 199,  199, 0, 0, 0};
        probes[2] = '{200, 1000, 200, 0, 0, 0};
        probes[3] = '{399, 1199, 399, 1, 0, 0};
        probes[4] = '{400, 0,    0,   0, 1, 1};
        probes[5] = '{599, 199,  199, 0, 1, 1};
        probes[6] = '{600, 1000, 200, 0, 1, 1};
        probes[7] = '{799, 1199, 399, 1, 1, 1};

        rst        = 1'b1;
        L5_en      = 1'b0;
        feat_ready = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Full run, ready held high.
        start();
        run_to_done(0, 1200, 1'b1);
        check("last_pulses", last_count, NP);
        for (int i = 0; i < 8; i++) begin
            check("probe_data",      seen[probes[i].pop].data,  probes[i].data);
            check("probe_index",     seen[probes[i].pop].idx,   probes[i].idx);
            check("probe_last",      seen[probes[i].pop].last,  probes[i].last);
            check("probe_pass",      seen[probes[i].pop].pass,  probes[i].pass);
            check("probe_pass_last", seen[probes[i].pop].plast, probes[i].plast);
        end
        done_hold_check();

        // Full run, random backpressure.
        start();
        run_to_done(1, 4000, 1'b0);
        L5_en = 1'b0;
        step(0);
        check("random_done_to_idle", L5_done, 0);

        // Stall at index 150 for 20 cycles.
        start();
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (feat_valid && feat_index == 9'd150) begin
                found      = 1'b1;
                feat_ready = 1'b0;
            end else begin
                feat_ready = 1'b1;
            end
            observe();
        end
        check("stall_reached", found, 1);
        for (int s = 1; s < 20; s++) begin
            step(2);
            check("stall_data", feat_data, 150);
            check("stall_index", feat_index, 150);
            if (s == 3) stall_addr = L4_read_addr;
            if (s > 3) check("addr_frozen", L4_read_addr, stall_addr);
        end

        // Abort at index 250, then restart from scratch.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (feat_valid && feat_index == 9'd250) begin
                found        = 1'b1;
                L5_en        = 1'b0;
                feat_ready   = 1'b0;
                hold_pending = 1'b0;
            end else begin
                feat_ready = 1'b1;
                observe();
            end
        end
        check("abort_reached", found, 1);
        @(negedge clk);
        check("abort_valid", feat_valid, 0);
        check("abort_index", feat_index, 0);
        check("abort_pass", pass_count, 0);
        check("abort_addr", L4_read_addr, 0);
        check("abort_done", L5_done, 0);
        start();
        for (int i = 0; i < 300 && exp_pos < 50; i++) step(0);
        check("restart_pops", exp_pos, 50);
        check("restart_latency", first_valid_cyc, FIRST_VALID_CYC);

        // Synchronous reset mid pass 1 with enable still high.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (feat_valid && pass_count == 7'd1 && feat_index == 9'd30) begin
                found      = 1'b1;
                rst        = 1'b1;
                feat_ready = 1'b0;
            end else begin
                feat_ready = 1'b1;
                observe();
            end
        end
        check("rst_reached", found, 1);
        @(negedge clk);
        check_reset_outputs("midrun_rst");
        rst = 1'b0;
        reset_model();
        run_to_done(0, 1200, 1'b1);
        done_hold_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d passed of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
